// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment capture path.
// Contents: active-low ABCDEFG patterns for hex digits 0..F, the all-off
// pattern, the decoder result payload and the capture FSM state encoding.
package seg7_pkg;

    // Active-low patterns, bit 6 = segment A, bit 0 = segment G.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Decoded digit: nibble is 0 whenever blank or err is set.
    typedef struct packed {
        logic [3:0] nibble;
        logic       blank;
        logic       err;
    } seg_dec_t;

    typedef enum logic {
        CAPTURE = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Inverse of the hex-to-7-segment display table.
// Ports:
//   pattern - active-low ABCDEFG segment pattern (bit 6 = A)
//   dec     - decoded {nibble, blank, err}
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output seg_dec_t   dec
);

    // Unknown patterns flag err and report nibble 0.
    always_comb begin
        dec = '0;
        case (pattern)
            SEG_0:     dec.nibble = 4'h0;
            SEG_1:     dec.nibble = 4'h1;
            SEG_2:     dec.nibble = 4'h2;
            SEG_3:     dec.nibble = 4'h3;
            SEG_4:     dec.nibble = 4'h4;
            SEG_5:     dec.nibble = 4'h5;
            SEG_6:     dec.nibble = 4'h6;
            SEG_7:     dec.nibble = 4'h7;
            SEG_8:     dec.nibble = 4'h8;
            SEG_9:     dec.nibble = 4'h9;
            SEG_A:     dec.nibble = 4'hA;
            SEG_B:     dec.nibble = 4'hB;
            SEG_C:     dec.nibble = 4'hC;
            SEG_D:     dec.nibble = 4'hD;
            SEG_E:     dec.nibble = 4'hE;
            SEG_F:     dec.nibble = 4'hF;
            SEG_BLANK: dec.blank  = 1'b1;
            default:   dec.err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_frame_capture.sv
// Recovers the hex digits shown on a multiplexed active-low 7-segment bus
// and presents each completed frame on a valid/ready interface.
// Ports:
//   HCLK, HRESET - clock, synchronous active-high reset
//   seg          - active-low segments {A..G}, bit 6 = A
//   an           - active-low digit enables, bit i = digit i
//   out_valid    - frame available (held until out_ready)
//   out_ready    - consumer accepts the frame
//   out_data     - nibble i at [4i+3:4i]
//   out_blank    - digit i was all-off
//   out_err      - digit i pattern not a hex code
//   timeout      - one-cycle pulse when an incomplete frame is abandoned
module seg_frame_capture
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 65535
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [DIGITS-1:0]     out_blank,
    output logic [DIGITS-1:0]     out_err,
    output logic                  timeout
);

    localparam int unsigned DW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    // Sampling pipeline: registered bus, previous registered bus, stable run.
    logic [DIGITS-1:0] an_q, an_p;
    logic [6:0]        seg_q, seg_p;
    logic [CW-1:0]     scnt, scnt_next;
    logic              cap_v;
    logic [DIGITS-1:0] cap_mask;
    seg_dec_t          cap_dec;
    seg_dec_t          dec_q;

    // Frame state.
    state_t            state, state_next;
    logic [DIGITS-1:0] seen, seen_next;
    logic [TW-1:0]     tcnt, tcnt_next;
    logic [DW-1:0]     slot_data, slot_data_next;
    logic [DIGITS-1:0] slot_blank, slot_blank_next;
    logic [DIGITS-1:0] slot_err, slot_err_next;
    logic              out_valid_next;
    logic [DW-1:0]     out_data_next;
    logic [DIGITS-1:0] out_blank_next, out_err_next;
    logic              timeout_next;

    logic [DIGITS-1:0] en;
    logic              sample_ok;
    logic              same;
    logic              at_max;
    logic              hit;
    logic              sampling;

    seg7_to_hex u_dec (
        .pattern (seg_q),
        .dec     (dec_q)
    );

    // Exactly one enable low; ghosting or an idle bus breaks the run.
    assign en        = ~an_q;
    assign sample_ok = (en != '0) && ((en & (en - DIGITS'(1))) == '0);
    assign same      = (an_q == an_p) && (seg_q == seg_p);
    assign at_max    = (scnt == CW'(STABLE_CYCLES));

    // Stable-run counter; a saturated run does not capture again.
    always_comb begin
        scnt_next = '0;
        if (sample_ok && same) begin
            scnt_next = at_max ? scnt : scnt + CW'(1);
        end else if (sample_ok) begin
            scnt_next = CW'(1);
        end
    end

    assign hit      = sample_ok && (scnt_next == CW'(STABLE_CYCLES)) && !(same && at_max);
    assign sampling = (state == CAPTURE) && (state_next == CAPTURE);

    // Input registers and capture staging.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            an_q     <= '1;
            seg_q    <= SEG_BLANK;
            an_p     <= '1;
            seg_p    <= SEG_BLANK;
            scnt     <= '0;
            cap_v    <= 1'b0;
            cap_mask <= '0;
            cap_dec  <= '0;
        end else begin
            an_q  <= an;
            seg_q <= seg;
            an_p  <= an_q;
            seg_p <= seg_q;
            if (sampling) begin
                scnt     <= scnt_next;
                cap_v    <= hit;
                cap_mask <= en;
                cap_dec  <= dec_q;
            end else begin
                scnt  <= '0;
                cap_v <= 1'b0;
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_next      = state;
        seen_next       = seen;
        tcnt_next       = tcnt;
        slot_data_next  = slot_data;
        slot_blank_next = slot_blank;
        slot_err_next   = slot_err;
        out_valid_next  = out_valid;
        out_data_next   = out_data;
        out_blank_next  = out_blank;
        out_err_next    = out_err;
        timeout_next    = 1'b0;

        case (state)
            CAPTURE: begin
                if (cap_v) begin
                    for (int unsigned i = 0; i < DIGITS; i++) begin
                        if (cap_mask[i]) begin
                            slot_data_next[4*i +: 4] = cap_dec.nibble;
                            slot_blank_next[i]       = cap_dec.blank;
                            slot_err_next[i]         = cap_dec.err;
                        end
                    end
                    seen_next = seen | cap_mask;
                end
                // Completion wins over a coincident timeout.
                if (&seen_next) begin
                    state_next     = PRESENT;
                    out_valid_next = 1'b1;
                    out_data_next  = slot_data_next;
                    out_blank_next = slot_blank_next;
                    out_err_next   = slot_err_next;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    timeout_next = 1'b1;
                    seen_next    = '0;
                    tcnt_next    = '0;
                end else begin
                    tcnt_next = tcnt + TW'(1);
                end
            end
            PRESENT: begin
                if (out_valid && out_ready) begin
                    state_next     = CAPTURE;
                    out_valid_next = 1'b0;
                    seen_next      = '0;
                    tcnt_next      = '0;
                end
            end
            default: state_next = CAPTURE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= CAPTURE;
            seen       <= '0;
            tcnt       <= '0;
            slot_data  <= '0;
            slot_blank <= '0;
            slot_err   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_blank  <= '0;
            out_err    <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_next;
            seen       <= seen_next;
            tcnt       <= tcnt_next;
            slot_data  <= slot_data_next;
            slot_blank <= slot_blank_next;
            slot_err   <= slot_err_next;
            out_valid  <= out_valid_next;
            out_data   <= out_data_next;
            out_blank  <= out_blank_next;
            out_err    <= out_err_next;
            timeout    <= timeout_next;
        end
    end

endmodule
